// File: rtl/instr_register_pkg.sv
// ============================================================================
// Module      : instr_register_pkg
// Description : Shared opcode encoding and default widths for instr_register_q.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_register_pkg;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    localparam int c_DEFAULT_DEPTH     = 32;
    localparam int c_DEFAULT_OPERAND_W = 32;

endpackage

`default_nettype wire

// File: rtl/instr_alu.sv
// ============================================================================
// Module      : instr_alu
// Description : Combinational signed ALU producing a double-width result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_alu
    import instr_register_pkg::*;
#(
    parameter int OPERAND_W = c_DEFAULT_OPERAND_W,
    localparam int RW = 2 * OPERAND_W
) (
    input  opcode_t                       opcode,
    input  logic signed [OPERAND_W-1:0]   operand_a,
    input  logic signed [OPERAND_W-1:0]   operand_b,
    output logic        [RW-1:0]          result,
    output logic                          div_err
);

    logic signed [RW-1:0] w_a;
    logic signed [RW-1:0] w_b;
    logic signed [RW-1:0] w_b_safe;
    logic                 w_b_zero;

    assign w_a      = {{OPERAND_W{operand_a[OPERAND_W-1]}}, operand_a};
    assign w_b      = {{OPERAND_W{operand_b[OPERAND_W-1]}}, operand_b};
    assign w_b_zero = (operand_b == '0);
    // Divider never sees zero; the zero case is reported through div_err instead.
    assign w_b_safe = w_b_zero ? RW'(1) : w_b;

    always_comb begin
        result  = '0;
        div_err = 1'b0;
        case (opcode)
            ZERO:  result = '0;
            PASSA: result = w_a;
            PASSB: result = w_b;
            ADD:   result = w_a + w_b;
            SUB:   result = w_a - w_b;
            MULT:  result = w_a * w_b;
            DIV: begin
                if (w_b_zero) div_err = 1'b1;
                else          result  = w_a / w_b_safe;
            end
            MOD: begin
                if (w_b_zero) div_err = 1'b1;
                else          result  = w_a % w_b_safe;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_register_q.sv
// ============================================================================
// Module      : instr_register_q
// Description : Two-stage instruction register with addressed or FIFO storage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_register_q
    import instr_register_pkg::*;
#(
    parameter int DEPTH     = c_DEFAULT_DEPTH,
    parameter int OPERAND_W = c_DEFAULT_OPERAND_W,
    parameter int MODE      = 0,
    localparam int AW = $clog2(DEPTH),
    localparam int RW = 2 * OPERAND_W,
    localparam int IW = 4 * OPERAND_W + 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_en,
    input  opcode_t                      opcode,
    input  logic signed [OPERAND_W-1:0]  operand_a,
    input  logic signed [OPERAND_W-1:0]  operand_b,
    input  logic        [AW-1:0]         write_pointer,
    output logic                         load_ready,
    input  logic                         read_en,
    input  logic        [AW-1:0]         read_pointer,
    output logic                         instruction_valid,
    output logic        [IW-1:0]         instruction_word,
    output logic        [AW:0]           count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic                         underflow
);

    typedef struct packed {
        opcode_t                     opcode;
        logic signed [OPERAND_W-1:0] op_a;
        logic signed [OPERAND_W-1:0] op_b;
        logic        [RW-1:0]        result;
        logic                        div_err;
    } instruction_t;

    instruction_t r_mem [DEPTH];
    instruction_t r_word;
    instruction_t w_commit;

    logic                        r_s1_valid;
    opcode_t                     r_s1_opcode;
    logic signed [OPERAND_W-1:0] r_s1_a;
    logic signed [OPERAND_W-1:0] r_s1_b;
    logic        [AW-1:0]        r_s1_wptr;

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_valid;
    logic          r_overflow;
    logic          r_underflow;

    logic [RW-1:0] w_alu_result;
    logic          w_alu_div_err;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_read;
    logic [AW-1:0] w_raddr;

    instr_alu #(.OPERAND_W(OPERAND_W)) u_alu (
        .opcode    (r_s1_opcode),
        .operand_a (r_s1_a),
        .operand_b (r_s1_b),
        .result    (w_alu_result),
        .div_err   (w_alu_div_err)
    );

    generate
        if (MODE == 1) begin : g_queue
            logic [AW:0] w_committed;
            // The entry sitting in stage 1 is counted but not yet poppable.
            assign w_committed = r_count - {{AW{1'b0}}, r_s1_valid};
            assign w_full      = (r_count == (AW+1)'(DEPTH));
            assign w_empty     = (w_committed == '0);
            assign load_ready  = !w_full;
            assign count       = r_count;
            assign full        = w_full;
            assign empty       = w_empty;
        end else begin : g_addressed
            assign w_full      = 1'b0;
            assign w_empty     = 1'b0;
            assign load_ready  = 1'b1;
            assign count       = '0;
            assign full        = 1'b0;
            assign empty       = 1'b0;
        end
    endgenerate

    assign w_push  = load_en && load_ready;
    assign w_read  = read_en && !w_empty;
    assign w_raddr = (MODE == 1) ? r_rptr : read_pointer;

    always_comb begin
        w_commit         = '0;
        w_commit.opcode  = r_s1_opcode;
        w_commit.op_a    = r_s1_a;
        w_commit.op_b    = r_s1_b;
        w_commit.result  = w_alu_result;
        w_commit.div_err = w_alu_div_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_opcode <= ZERO;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_wptr   <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_word      <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_s1_valid <= w_push;
            if (w_push) begin
                r_s1_opcode <= opcode;
                r_s1_a      <= operand_a;
                r_s1_b      <= operand_b;
                r_s1_wptr   <= (MODE == 1) ? r_wptr : write_pointer;
            end
            if (r_s1_valid) r_mem[r_s1_wptr] <= w_commit;

            // Non-blocking read of r_mem gives old contents on a same-edge commit.
            r_valid <= w_read;
            if (w_read) r_word <= r_mem[w_raddr];

            r_overflow  <= load_en && !load_ready;
            r_underflow <= (MODE == 1) && read_en && w_empty;

            if (MODE == 1) begin
                if (w_push) r_wptr <= r_wptr + AW'(1);
                if (w_read) r_rptr <= r_rptr + AW'(1);
                r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_read);
            end
        end
    end

    assign instruction_valid = r_valid;
    assign instruction_word  = r_word;
    assign overflow          = r_overflow;
    assign underflow         = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_instr_register_q.sv
// ============================================================================
// Module      : tb_instr_register_q
// Description : Scoreboard bench for addressed (DEPTH 32) and queue (DEPTH 4) builds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_register_q;
    import instr_register_pkg::*;

    localparam int OW = 32;
    localparam int RW = 64;
    localparam int IW = 4 * OW + 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // addressed instance
    logic rst0, l0, re0;
    opcode_t op0;
    logic signed [OW-1:0] a0, b0;
    logic [4:0] wp0, rp0;
    logic lr0, v0, f0, e0, ov0, un0;
    logic [IW-1:0] w0;
    logic [5:0] c0;

    // queue instance
    logic rst1, l1, re1;
    opcode_t op1;
    logic signed [OW-1:0] a1, b1;
    logic [1:0] wp1, rp1;
    logic lr1, v1, f1, e1, ov1, un1;
    logic [IW-1:0] w1;
    logic [2:0] c1;

    instr_register_q #(.DEPTH(32), .OPERAND_W(OW), .MODE(0)) u_dut0 (
        .clk(clk), .reset(rst0), .load_en(l0), .opcode(op0),
        .operand_a(a0), .operand_b(b0), .write_pointer(wp0), .load_ready(lr0),
        .read_en(re0), .read_pointer(rp0), .instruction_valid(v0),
        .instruction_word(w0), .count(c0), .full(f0), .empty(e0),
        .overflow(ov0), .underflow(un0)
    );

    instr_register_q #(.DEPTH(4), .OPERAND_W(OW), .MODE(1)) u_dut1 (
        .clk(clk), .reset(rst1), .load_en(l1), .opcode(op1),
        .operand_a(a1), .operand_b(b1), .write_pointer(wp1), .load_ready(lr1),
        .read_en(re1), .read_pointer(rp1), .instruction_valid(v1),
        .instruction_word(w1), .count(c1), .full(f1), .empty(e1),
        .overflow(ov1), .underflow(un1)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [IW-1:0] q0[$];
    logic [IW-1:0] q1[$];

    task automatic chk(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(opcode_t op, logic [OW-1:0] a, logic [OW-1:0] b,
                                         logic [RW-1:0] r, logic err);
        return {op, a, b, r, err};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitors: every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (v0) begin
            if (q0.size() == 0) chk("valid0_unexpected", IW'(v0), '0);
            else                chk("word0", w0, q0.pop_front());
        end
        if (v1) begin
            if (q1.size() == 0) chk("valid1_unexpected", IW'(v1), '0);
            else                chk("word1", w1, q1.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    opcode_t       t_op [7];
    logic [OW-1:0] t_a  [7];
    logic [OW-1:0] t_b  [7];
    logic [RW-1:0] t_r  [7];
    logic          t_e  [7];

    initial begin
        t_op[0] = MULT;  t_a[0] = 32'h7FFF_FFFF; t_b[0] = 32'd2;          t_r[0] = 64'h0000_0000_FFFF_FFFE; t_e[0] = 1'b0;
        t_op[1] = DIV;   t_a[1] = 32'd9;         t_b[1] = 32'd0;          t_r[1] = 64'h0;                   t_e[1] = 1'b1;
        t_op[2] = SUB;   t_a[2] = 32'd5;         t_b[2] = 32'd9;          t_r[2] = 64'hFFFF_FFFF_FFFF_FFFC; t_e[2] = 1'b0;
        t_op[3] = MOD;   t_a[3] = 32'hFFFF_FFF9; t_b[3] = 32'd2;          t_r[3] = 64'hFFFF_FFFF_FFFF_FFFF; t_e[3] = 1'b0;
        t_op[4] = DIV;   t_a[4] = 32'hFFFF_FFF9; t_b[4] = 32'd2;          t_r[4] = 64'hFFFF_FFFF_FFFF_FFFD; t_e[4] = 1'b0;
        t_op[5] = PASSB; t_a[5] = 32'd1;         t_b[5] = 32'hFFFF_FFFF;  t_r[5] = 64'hFFFF_FFFF_FFFF_FFFF; t_e[5] = 1'b0;
        t_op[6] = ZERO;  t_a[6] = 32'd1;         t_b[6] = 32'd2;          t_r[6] = 64'h0;                   t_e[6] = 1'b0;

        rst0 = 1'b1; l0 = 1'b0; re0 = 1'b0; op0 = ZERO; a0 = '0; b0 = '0; wp0 = '0; rp0 = '0;
        rst1 = 1'b1; l1 = 1'b0; re1 = 1'b0; op1 = ZERO; a1 = '0; b1 = '0; wp1 = '0; rp1 = '0;
        tick(); tick();
        rst0 = 1'b0; rst1 = 1'b0;

        chk("reset0_ready", IW'(lr0), IW'(1));
        chk("reset0_status", IW'({c0, f0, e0, ov0, un0, v0}), '0);
        chk("reset0_word", w0, '0);
        chk("reset1_status", IW'({lr1, c1, f1, e1, ov1, un1, v1}), IW'(11'b1_000_0_1_0_0_0));

        // Unwritten address reads back as zero with valid
        re0 = 1'b1; rp0 = 5'd5; q0.push_back('0); tick();
        re0 = 1'b0;

        // ADD at wp 2; read at N+1 sees old contents, N+2 sees the result
        l0 = 1'b1; op0 = ADD; a0 = 32'd7; b0 = 32'hFFFF_FFFD; wp0 = 5'd2; tick();
        l0 = 1'b0; re0 = 1'b1; rp0 = 5'd2; q0.push_back('0); tick();
        q0.push_back(mk(ADD, 32'd7, 32'hFFFF_FFFD, 64'd4, 1'b0)); tick();
        re0 = 1'b0;

        for (int i = 0; i < 7; i++) begin
            l0 = 1'b1; op0 = t_op[i]; a0 = t_a[i]; b0 = t_b[i]; wp0 = 5'(3 + i); tick();
        end
        l0 = 1'b0; tick();
        chk("mode0_overflow", IW'({ov0, un0}), '0);
        for (int i = 0; i < 7; i++) begin
            re0 = 1'b1; rp0 = 5'(3 + i); q0.push_back(mk(t_op[i], t_a[i], t_b[i], t_r[i], t_e[i])); tick();
        end
        re0 = 1'b0; tick();

        // Queue: fill to DEPTH
        for (int i = 0; i < 4; i++) begin
            l1 = 1'b1; op1 = PASSA; a1 = 10 + i; b1 = '0; tick();
            if (i == 0) chk("q_first_push_cnt_empty", IW'({c1, e1}), IW'({3'd1, 1'b1}));
        end
        chk("q_full", IW'({c1, f1, lr1}), IW'({3'd4, 1'b1, 1'b0}));
        a1 = 32'd99; tick();
        chk("q_overflow", IW'({ov1, c1}), IW'({1'b1, 3'd4}));
        l1 = 1'b0; tick();
        chk("q_overflow_pulse", IW'(ov1), '0);
        for (int i = 0; i < 4; i++) begin
            re1 = 1'b1; q1.push_back(mk(PASSA, OW'(10 + i), '0, RW'(10 + i), 1'b0)); tick();
        end
        tick();
        chk("q_underflow", IW'({un1, v1, c1, e1}), IW'({1'b1, 1'b0, 3'd0, 1'b1}));
        re1 = 1'b0; tick();
        chk("q_underflow_pulse", IW'(un1), '0);

        // Queue: interleaved push/pop crossing the wrap point
        op1 = ADD; b1 = 32'd100;
        l1 = 1'b1; a1 = 32'd0; tick();
        a1 = 32'd1; tick();
        for (int i = 2; i < 6; i++) begin
            a1 = i; re1 = 1'b1;
            q1.push_back(mk(ADD, OW'(i - 2), OW'(100), RW'(i - 2 + 100), 1'b0)); tick();
            chk("q_simul_count", IW'(c1), IW'(3'd2));
        end
        l1 = 1'b0;
        q1.push_back(mk(ADD, OW'(4), OW'(100), RW'(104), 1'b0)); tick();
        q1.push_back(mk(ADD, OW'(5), OW'(100), RW'(105), 1'b0)); tick();
        re1 = 1'b0; tick();
        chk("q_drained", IW'({c1, e1}), IW'({3'd0, 1'b1}));

        // Reset right after a load discards the in-flight entry
        l1 = 1'b1; op1 = ADD; a1 = 32'd50; b1 = 32'd1; tick();
        chk("q_inflight_count", IW'(c1), IW'(3'd1));
        l1 = 1'b0; rst1 = 1'b1; tick();
        rst1 = 1'b0;
        chk("q_reset_status", IW'({c1, e1}), IW'({3'd0, 1'b1}));
        re1 = 1'b1; tick();
        chk("q_reset_read", IW'({un1, v1}), IW'({1'b1, 1'b0}));
        re1 = 1'b0; tick(); tick();

        chk("q0_leftover", IW'(q0.size()), '0);
        chk("q1_leftover", IW'(q1.size()), '0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
